// File: rtl/mem_stream_reader_if.sv
// Control, RAM read-port and output-stream signals of mem_stream_reader.
// MEM_STREAM_READER_LAST_EN adds the dout_last stream sideband.
interface mem_stream_reader_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_q;
  logic [WIDTH-1:0]  dout;
  logic              dout_valid;
  logic              dout_ready;
`ifdef MEM_STREAM_READER_LAST_EN
  logic              dout_last;
`endif

  modport master (
    input  start, start_addr, length, mem_q, dout_ready,
`ifdef MEM_STREAM_READER_LAST_EN
    output dout_last,
`endif
    output busy, done, mem_addr, dout, dout_valid
  );

  modport slave (
    output start, start_addr, length, mem_q, dout_ready,
`ifdef MEM_STREAM_READER_LAST_EN
    input  dout_last,
`endif
    input  busy, done, mem_addr, dout, dout_valid
  );
endinterface

// File: rtl/mem_stream_reader.sv
// Drains a contiguous RAM address range into a valid/ready stream via a 4-entry FIFO.
// MEM_STREAM_READER_LAST_EN: carries a last-word flag through the FIFO onto dout_last.
module mem_stream_reader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input logic                  clock,
  input logic                  rst,
  mem_stream_reader_if.master  io_bus
);
  localparam int ADDR_W = $clog2(DEPTH);
`ifdef MEM_STREAM_READER_LAST_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr, r_mem_addr;
  logic [ADDR_W:0]   r_rem;
  // r_p1: address sits in the RAM input register; r_p2: mem_q carries that word
  logic              r_p1, r_p2;
  logic [EW-1:0]     r_fifo [4];
  logic [1:0]        r_wp, r_rp;
  logic [2:0]        r_cnt;
  logic [EW-1:0]     r_out;
  logic              r_dv, r_busy, r_done;
`ifdef MEM_STREAM_READER_LAST_EN
  logic              r_l1, r_l2;
`endif

  logic              w_issue, w_out_free, w_from_fifo, w_bypass, w_push, w_drained;
  logic [EW-1:0]     w_q;
  logic [ADDR_W-1:0] w_addr_nx;

  always_comb begin
    w_issue     = (r_state == S_READ) && (r_rem != '0) &&
                  ((4'(r_cnt) + 4'(r_p1) + 4'(r_p2)) <= 4'd3);
    w_out_free  = !r_dv || io_bus.dout_ready;
    w_from_fifo = w_out_free && (r_cnt != 3'd0);
    // Empty FIFO: RAM data goes straight to the output register to keep 3-cycle latency
    w_bypass    = w_out_free && (r_cnt == 3'd0) && r_p2;
    w_push      = r_p2 && !w_bypass;
    w_drained   = !r_p1 && !r_p2 && (r_cnt == 3'd0) && w_out_free;
    w_addr_nx   = (r_addr == ADDR_W'(DEPTH - 1)) ? '0 : r_addr + ADDR_W'(1);
`ifdef MEM_STREAM_READER_LAST_EN
    w_q         = {r_l2, io_bus.mem_q};
`else
    w_q         = io_bus.mem_q;
`endif
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_mem_addr <= '0;
      r_rem      <= '0;
      r_p1       <= 1'b0;
      r_p2       <= 1'b0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_out      <= '0;
      r_dv       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef MEM_STREAM_READER_LAST_EN
      r_l1       <= 1'b0;
      r_l2       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;

      if (w_from_fifo) begin
        r_out <= r_fifo[r_rp];
        r_rp  <= r_rp + 2'd1;
        r_dv  <= 1'b1;
      end else if (w_bypass) begin
        r_out <= w_q;
        r_dv  <= 1'b1;
      end else if (w_out_free) begin
        r_dv  <= 1'b0;
      end

      if (w_push) begin
        r_fifo[r_wp] <= w_q;
        r_wp         <= r_wp + 2'd1;
      end
      r_cnt <= r_cnt + 3'(w_push) - 3'(w_from_fifo);

      r_p1 <= w_issue;
      r_p2 <= r_p1;
`ifdef MEM_STREAM_READER_LAST_EN
      r_l1 <= w_issue && (r_rem == (ADDR_W+1)'(1));
      r_l2 <= r_l1;
`endif
      if (w_issue) begin
        r_mem_addr <= r_addr;
        r_addr     <= w_addr_nx;
        r_rem      <= r_rem - (ADDR_W+1)'(1);
      end

      case (r_state)
        S_IDLE: if (io_bus.start) begin
          if (io_bus.length != '0) begin
            r_state <= S_READ;
            r_addr  <= io_bus.start_addr;
            r_rem   <= io_bus.length;
            r_busy  <= 1'b1;
          end else begin
            r_done  <= 1'b1;
          end
        end
        S_READ: if (w_issue && (r_rem == (ADDR_W+1)'(1))) r_state <= S_DRAIN;
        S_DRAIN: if (w_drained) begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.busy       = r_busy;
  assign io_bus.done       = r_done;
  assign io_bus.mem_addr   = r_mem_addr;
  assign io_bus.dout       = r_out[WIDTH-1:0];
  assign io_bus.dout_valid = r_dv;
`ifdef MEM_STREAM_READER_LAST_EN
  assign io_bus.dout_last  = r_dv & r_out[WIDTH];
`endif
endmodule

// File: tb/tb_mem_stream_reader.sv
// Self-checking bench for mem_stream_reader: queue-based stream model plus directed literal checks.
// Builds with or without MEM_STREAM_READER_LAST_EN.
module tb_mem_stream_reader;
  localparam int WIDTH = 8;
  localparam int DEPTH = 64;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_stream_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus();
  mem_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock  (clock),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clock = ~clock;

  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clock) bus.mem_q <= mem[bus.mem_addr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Model: queue of words still owed on the stream, plus busy/done expectations.
  typedef struct { int d; bit last; } word_t;
  word_t m_q[$];
  bit    m_busy   = 0;
  bit    done_due = 0;
  bit    stalled  = 0;
  int    held     = 0;
  int    cyc      = 0;
  int    done_cnt = 0;
  int    done_cyc = 0;
  int    start_cyc = 0;
  int    hs_data[$];
  int    hs_cyc[$];
  int    hs_last[$];

  always @(negedge clock) begin
    cyc++;
    if (rst) begin
      m_q.delete();
      m_busy   = 0;
      done_due = 0;
      stalled  = 0;
    end else begin
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, done_due);
      chk("occupancy_le4", int'((dut.r_cnt + dut.r_p1 + dut.r_p2) <= 4), 1);
      if (bus.done) begin done_cnt++; done_cyc = cyc; end
      if (stalled) begin
        chk("stall_valid", bus.dout_valid, 1);
        chk("stall_data", bus.dout, held);
      end
      if (bus.dout_valid) begin
        if (m_q.size() == 0) chk("spurious_valid", bus.dout_valid, 0);
        else begin
          chk("dout", bus.dout, m_q[0].d);
`ifdef MEM_STREAM_READER_LAST_EN
          chk("dout_last", bus.dout_last, m_q[0].last);
`endif
        end
      end
`ifdef MEM_STREAM_READER_LAST_EN
      else chk("last_idle", bus.dout_last, 0);
`endif
      done_due = 0;
      if (bus.dout_valid && bus.dout_ready && m_q.size() > 0) begin
        hs_data.push_back(bus.dout);
        hs_cyc.push_back(cyc);
`ifdef MEM_STREAM_READER_LAST_EN
        hs_last.push_back(bus.dout_last);
`endif
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin m_busy = 0; done_due = 1; end
      end
      if (bus.start && !m_busy) begin
        start_cyc = cyc;
        if (bus.length == 0) done_due = 1;
        else begin
          m_busy = 1;
          for (int i = 0; i < int'(bus.length); i++) begin
            word_t w;
            w.d    = (int'(bus.start_addr) + i) % DEPTH;
            w.last = (i == int'(bus.length) - 1);
            m_q.push_back(w);
          end
        end
      end
      stalled = bus.dout_valid && !bus.dout_ready;
      held    = bus.dout;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic go(input int a, input int l);
    bus.start      = 1'b1;
    bus.start_addr = 6'(a);
    bus.length     = 7'(l);
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin step(1); k++; end
    chk("done_timeout", int'(done_cnt >= target), 1);
  endtask

  task automatic clear_log();
    hs_data.delete(); hs_cyc.delete(); hs_last.delete();
  endtask

  initial begin
    int base, k;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
    bus.start = 1'b0; bus.start_addr = '0; bus.length = '0; bus.dout_ready = 1'b1;
    step(3);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_valid", bus.dout_valid, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_dout", bus.dout, 0);
    rst = 1'b0;
    step(2);

    // Basic: 5..12 back to back
    clear_log();
    base = done_cnt;
    go(5, 8);
    wait_done(base + 1, 100);
    chk("t1_count", hs_data.size(), 8);
    if (hs_data.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("t1_word", hs_data[i], 5 + i);
      chk("t1_first_latency", hs_cyc[0] - start_cyc, 4);
      chk("t1_no_gaps", hs_cyc[7] - hs_cyc[0], 7);
      chk("t1_done_after_last", done_cyc - hs_cyc[7], 1);
    end
    step(2);

    // Address wrap
    clear_log();
    base = done_cnt;
    go(62, 4);
    wait_done(base + 1, 100);
    chk("t2_count", hs_data.size(), 4);
    if (hs_data.size() == 4) begin
      chk("t2_w0", hs_data[0], 62);
      chk("t2_w1", hs_data[1], 63);
      chk("t2_w2", hs_data[2], 0);
      chk("t2_w3", hs_data[3], 1);
`ifdef MEM_STREAM_READER_LAST_EN
      for (int i = 0; i < 4; i++) chk("t2_last", hs_last[i], int'(i == 3));
`endif
    end
    step(2);

    // Zero length
    clear_log();
    base = done_cnt;
    go(7, 0);
    step(4);
    chk("t3_done_once", done_cnt - base, 1);
    chk("t3_done_latency", done_cyc - start_cyc, 1);
    chk("t3_no_words", hs_data.size(), 0);

    // Backpressure, ready roughly 1 on / 2 off
    clear_log();
    base = done_cnt;
    bus.dout_ready = 1'b0;
    go(20, 16);
    k = 0;
    while (done_cnt < base + 1 && k < 600) begin
      bus.dout_ready = ($urandom_range(0, 2) == 0);
      step(1);
      k++;
    end
    bus.dout_ready = 1'b1;
    chk("t4_done", int'(done_cnt >= base + 1), 1);
    chk("t4_count", hs_data.size(), 16);
    if (hs_data.size() == 16)
      for (int i = 0; i < 16; i++) chk("t4_word", hs_data[i], 20 + i);
    step(2);

    // Reset after the 3rd word of a 10-word transfer
    clear_log();
    base = done_cnt;
    go(30, 10);
    k = 0;
    while (hs_data.size() < 3 && k < 100) begin step(1); k++; end
    chk("t5_three_words", hs_data.size(), 3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    chk("t5_busy_cleared", bus.busy, 0);
    chk("t5_valid_cleared", bus.dout_valid, 0);
    step(6);
    chk("t5_no_done", done_cnt - base, 0);
    chk("t5_no_more_words", hs_data.size(), 3);
    clear_log();
    go(0, 2);
    wait_done(base + 1, 100);
    chk("t5_restart_count", hs_data.size(), 2);
    if (hs_data.size() == 2) begin
      chk("t5_w0", hs_data[0], 0);
      chk("t5_w1", hs_data[1], 1);
    end
    step(2);

    // Start while busy is ignored; start in the done cycle is accepted
    clear_log();
    base = done_cnt;
    go(40, 6);
    step(1);
    go(0, 3);
    k = 0;
    while (!bus.done && k < 100) begin step(1); k++; end
    chk("t6_done_seen", bus.done, 1);
    go(50, 3);
    wait_done(base + 2, 100);
    chk("t6_count", hs_data.size(), 9);
    if (hs_data.size() == 9) begin
      for (int i = 0; i < 6; i++) chk("t6_first", hs_data[i], 40 + i);
      for (int i = 0; i < 3; i++) chk("t6_second", hs_data[6 + i], 50 + i);
    end
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
